traffic_request_encoder: RTL and testbench

Front end that drives the 2-bit demand input `in` of the Mealy traffic controller. It synchronises and debounces the raw north-south (NS) and east-west (EW) vehicle sensors and latches one demand per road. Each demand is cleared when the controller's light output shows that road going green. It closes the loop between the road sensors and the controller's `in`/`o` pair.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/sensor_debounce.sv | 69 ++++++
 rtl/traffic_request_encoder.sv | 146 ++++++++++++++
 tb/tb_traffic_request_encoder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: constants shared between the traffic controller and its
// request encoder front end (demand codes and light-output bit positions).
package traffic_pkg;

    // Demand code presented on the controller's `in` input.
    typedef enum logic [1:0] {
        DEM_NONE = 2'b00,
        DEM_NS   = 2'b01,
        DEM_EW   = 2'b10,
        DEM_BOTH = 2'b11
    } dem_code_e;

    // Bit positions inside the controller's 4-bit light output `o`.
    localparam int unsigned NS_GRN = 3;
    localparam int unsigned NS_RED = 2;
    localparam int unsigned EW_GRN = 1;
    localparam int unsigned EW_RED = 0;

    // Road index used for per-road arrays (matches bit order of in_code).
    localparam int unsigned ROAD_NS = 0;
    localparam int unsigned ROAD_EW = 1;

endpackage : traffic_pkg

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchroniser, counting debouncer and
// rising/falling edge detection for one raw road sensor. While `en` is low
// the synchroniser keeps sampling but the debouncer and edge register hold,
// so an edge that happens during the freeze is seen once `en` returns.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic res_n,
    input  logic en,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Last count value before the debounced level flips (DEBOUNCE is 1..255).
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    logic [1:0] sync_r;
    logic [7:0] cnt_r;
    logic       deb_r;
    logic       prev_r;

    // Two-flop synchroniser for the asynchronous sensor; never frozen.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Debouncer: count cycles the synchronised input disagrees, flip on DEBOUNCE.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_r <= 8'd0;
            deb_r <= 1'b0;
        end else if (en) begin
            if (sync_r[1] == deb_r) begin
                cnt_r <= 8'd0;
            end else if (cnt_r == CNT_LAST) begin
                deb_r <= ~deb_r;
                cnt_r <= 8'd0;
            end else begin
                cnt_r <= cnt_r + 8'd1;
            end
        end else begin
            cnt_r <= cnt_r;
            deb_r <= deb_r;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            prev_r <= 1'b0;
        end else if (en) begin
            prev_r <= deb_r;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign level = deb_r;
    assign rise  = deb_r & ~prev_r;
    assign fall  = ~deb_r & prev_r;

endmodule : sensor_debounce

// File: rtl/traffic_request_encoder.sv
// traffic_request_encoder: turns debounced NS/EW sensor edges into latched
// demands for the traffic controller and clears each demand when that road's
// green light comes on. in_code comes straight from the latch flops.
// Optional feature: define TRAFFIC_ENC_STUCK_EN to add per-road stuck-sensor
// detection (adds the STUCK_CYC parameter and the `stuck` output).
module traffic_request_encoder
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE  = 4
`ifdef TRAFFIC_ENC_STUCK_EN
    ,
    parameter int unsigned STUCK_CYC = 1024
`endif
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       en,
    input  logic       sens_ns,
    input  logic       sens_ew,
    input  logic [3:0] o,
`ifdef TRAFFIC_ENC_STUCK_EN
    output logic [1:0] stuck,
`endif
    output logic [1:0] in_code
);

    logic [1:0] level_s;
    logic [1:0] rise_s;
    logic [1:0] fall_s;
    logic [1:0] grn_r;
    logic [1:0] grn_d_r;
    logic [1:0] clr_s;
    logic [1:0] mask_s;
    logic [1:0] lat_r;

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_ns (
        .clk   (clk),
        .res_n (res_n),
        .en    (en),
        .raw   (sens_ns),
        .level (level_s[ROAD_NS]),
        .rise  (rise_s[ROAD_NS]),
        .fall  (fall_s[ROAD_NS])
    );

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_ew (
        .clk   (clk),
        .res_n (res_n),
        .en    (en),
        .raw   (sens_ew),
        .level (level_s[ROAD_EW]),
        .rise  (rise_s[ROAD_EW]),
        .fall  (fall_s[ROAD_EW])
    );

    // Red bits play no part in clearing demands.
    logic unused_red_s;
    assign unused_red_s = ^{o[NS_RED], o[EW_RED]};

    // Two-stage registered copy of the green bits; the edge is taken between
    // the stages so the controller output never reaches the latch directly.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            grn_r   <= 2'b00;
            grn_d_r <= 2'b00;
        end else if (en) begin
            grn_r   <= {o[EW_GRN], o[NS_GRN]};
            grn_d_r <= grn_r;
        end else begin
            grn_r   <= grn_r;
            grn_d_r <= grn_d_r;
        end
    end

    assign clr_s = grn_r & ~grn_d_r;

`ifdef TRAFFIC_ENC_STUCK_EN
    localparam int unsigned SCW = $clog2(STUCK_CYC + 1);
    localparam logic [SCW-1:0] STUCK_MAX = SCW'(STUCK_CYC);
    localparam logic [SCW-1:0] STUCK_PRE = SCW'(STUCK_CYC - 1);

    logic [SCW-1:0] scnt_r [2];
    logic [1:0]     stuck_r;

    // Per-road saturating count of debounced-high cycles; a debounced fall restarts it.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            scnt_r[0] <= '0;
            scnt_r[1] <= '0;
            stuck_r   <= 2'b00;
        end else if (en) begin
            for (int r = 0; r < 2; r++) begin
                if (fall_s[r]) begin
                    scnt_r[r]  <= '0;
                    stuck_r[r] <= 1'b0;
                end else if (level_s[r] && (scnt_r[r] != STUCK_MAX)) begin
                    scnt_r[r] <= scnt_r[r] + {{(SCW-1){1'b0}}, 1'b1};
                    if (scnt_r[r] == STUCK_PRE) begin
                        stuck_r[r] <= 1'b1;
                    end else begin
                        stuck_r[r] <= stuck_r[r];
                    end
                end else begin
                    scnt_r[r]  <= scnt_r[r];
                    stuck_r[r] <= stuck_r[r];
                end
            end
        end else begin
            scnt_r[0] <= scnt_r[0];
            scnt_r[1] <= scnt_r[1];
            stuck_r   <= stuck_r;
        end
    end

    assign mask_s = stuck_r;
    assign stuck  = stuck_r;
`else
    assign mask_s = 2'b00;

    // Level and falling edge only feed the stuck detector.
    logic unused_deb_s;
    assign unused_deb_s = ^{level_s, fall_s};
`endif

    // Demand latches: clear (green edge or stuck) wins over a new debounced rise.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            lat_r <= 2'b00;
        end else if (en) begin
            for (int r = 0; r < 2; r++) begin
                if (clr_s[r] || mask_s[r]) begin
                    lat_r[r] <= 1'b0;
                end else if (rise_s[r]) begin
                    lat_r[r] <= 1'b1;
                end else begin
                    lat_r[r] <= lat_r[r];
                end
            end
        end else begin
            lat_r <= lat_r;
        end
    end

    assign in_code = lat_r;

endmodule : traffic_request_encoder

// File: tb/tb_traffic_request_encoder.sv
// Self-checking bench for traffic_request_encoder: directed scenarios with
// fixed expectations plus randomized traffic checked cycle by cycle against
// a behavioural model of the sensor-to-demand path.
module tb_traffic_request_encoder;

    localparam int D   = 4;
    localparam int STK = 16;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       en = 1'b1;
    logic       sens_ns = 1'b0;
    logic       sens_ew = 1'b0;
    logic [3:0] o = 4'b0101;
    logic [1:0] in_code;
`ifdef TRAFFIC_ENC_STUCK_EN
    logic [1:0] stuck;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef TRAFFIC_ENC_STUCK_EN
    traffic_request_encoder #(.DEBOUNCE(D), .STUCK_CYC(STK)) dut (
        .clk(clk), .res_n(res_n), .en(en), .sens_ns(sens_ns), .sens_ew(sens_ew),
        .o(o), .stuck(stuck), .in_code(in_code));
`else
    traffic_request_encoder #(.DEBOUNCE(D)) dut (
        .clk(clk), .res_n(res_n), .en(en), .sens_ns(sens_ns), .sens_ew(sens_ew),
        .o(o), .in_code(in_code));
`endif

    // ---------------- behavioural model ----------------
    logic [1:0] m_s1, m_s2, m_deb, m_prev, m_lat, m_stk;
    int         m_cnt [2];
    int         m_scnt [2];
    logic [3:0] m_o1, m_o2;

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_deb = 2'b00; m_prev = 2'b00;
        m_lat = 2'b00; m_stk = 2'b00; m_o1 = 4'b0000; m_o2 = 4'b0000;
        for (int r = 0; r < 2; r++) begin
            m_cnt[r] = 0;
            m_scnt[r] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [1:0] raw;
        logic [1:0] grn;
        logic       old;
        raw = {sens_ew, sens_ns};
        if (!res_n) begin
            model_reset();
            return;
        end
        if (en) begin
            grn[0] = m_o1[3] & ~m_o2[3];
            grn[1] = m_o1[1] & ~m_o2[1];
            for (int r = 0; r < 2; r++) begin
                old = m_deb[r];
                if (grn[r] || m_stk[r]) m_lat[r] = 1'b0;
                else if (old && !m_prev[r]) m_lat[r] = 1'b1;
`ifdef TRAFFIC_ENC_STUCK_EN
                if (!old && m_prev[r]) begin
                    m_scnt[r] = 0;
                    m_stk[r] = 1'b0;
                end else if (old && m_scnt[r] < STK) begin
                    m_scnt[r]++;
                    if (m_scnt[r] == STK) m_stk[r] = 1'b1;
                end
`endif
                if (m_s2[r] != old) begin
                    m_cnt[r]++;
                    if (m_cnt[r] == D) begin
                        m_deb[r] = ~old;
                        m_cnt[r] = 0;
                    end
                end else begin
                    m_cnt[r] = 0;
                end
                m_prev[r] = old;
            end
            m_o2 = m_o1;
            m_o1 = o;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        res_n = 1'b0; en = 1'b1; sens_ns = 1'b0; sens_ew = 1'b0; o = 4'b0101;
        model_reset();
        repeat (3) step();
        res_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (in_code !== 2'b00) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: in_code=%b expected 00", i, in_code);
            end
`ifdef TRAFFIC_ENC_STUCK_EN
            n_vec++;
            if (stuck !== 2'b00) begin
                n_err++;
                $display("FAIL reset_idle_stuck cyc %0d: stuck=%b expected 00", i, stuck);
            end
`endif
        end
        // Build a pending demand, then assert reset asynchronously mid-cycle.
        sens_ns = 1'b1;
        repeat (8) step();
        n_vec++;
        if (in_code !== 2'b01) begin
            n_err++;
            $display("FAIL reset_pre_demand: in_code=%b expected 01", in_code);
        end
        #2 res_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (in_code !== 2'b00) begin
            n_err++;
            $display("FAIL reset_async: in_code=%b expected 00", in_code);
        end
        @(negedge clk);
        sens_ns = 1'b0;
        step();
        res_n = 1'b1;
        repeat (10) step();
        n_vec++;
        if (in_code !== 2'b00) begin
            n_err++;
            $display("FAIL reset_no_memory: in_code=%b expected 00", in_code);
        end
    endtask

    task automatic test_ns_demand();
        logic [1:0] exp;
        apply_reset();
        sens_ns = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            exp = (e == 6) ? 2'b01 : 2'b00;
            n_vec++;
            if (in_code !== exp) begin
                n_err++;
                $display("FAIL ns_latency edge %0d: in_code=%b expected %b", e, in_code, exp);
            end
        end
        o = 4'b1001;
        step();
        n_vec++;
        if (in_code !== 2'b01) begin
            n_err++;
            $display("FAIL ns_clear_early: in_code=%b expected 01", in_code);
        end
        step();
        n_vec++;
        if (in_code !== 2'b00) begin
            n_err++;
            $display("FAIL ns_clear: in_code=%b expected 00", in_code);
        end
        // Sensor still high: no re-arm without a new debounced rise.
        o = 4'b0110;
        repeat (10) step();
        n_vec++;
        if (in_code !== 2'b00) begin
            n_err++;
            $display("FAIL ns_no_rearm: in_code=%b expected 00", in_code);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            sens_ew = (i < 3) || (i >= 4 && i < 7);
            step();
            n_vec++;
            if (in_code !== 2'b00) begin
                n_err++;
                $display("FAIL bounce_reject cyc %0d: in_code=%b expected 00", i, in_code);
            end
        end
        sens_ew = 1'b1;
        repeat (7) step();
        n_vec++;
        if (in_code !== 2'b10) begin
            n_err++;
            $display("FAIL bounce_hold: in_code=%b expected 10", in_code);
        end
    endtask

    task automatic test_both_simultaneous();
        apply_reset();
        sens_ns = 1'b1; sens_ew = 1'b1;
        repeat (6) step();
        n_vec++;
        if (in_code !== 2'b00) begin
            n_err++;
            $display("FAIL both_early: in_code=%b expected 00", in_code);
        end
        step();
        n_vec++;
        if (in_code !== 2'b11) begin
            n_err++;
            $display("FAIL both_set: in_code=%b expected 11", in_code);
        end
        // Debounced fall must not cancel the EW demand.
        sens_ew = 1'b0;
        repeat (8) step();
        n_vec++;
        if (in_code !== 2'b11) begin
            n_err++;
            $display("FAIL both_fall_keeps: in_code=%b expected 11", in_code);
        end
        // New EW rise arrives on the same edge as the EW green edge.
        sens_ew = 1'b1;
        repeat (5) step();
        o = 4'b0110;
        step();
        n_vec++;
        if (in_code !== 2'b11) begin
            n_err++;
            $display("FAIL both_pre_collide: in_code=%b expected 11", in_code);
        end
        step();
        n_vec++;
        if (in_code !== 2'b01) begin
            n_err++;
            $display("FAIL both_clear_wins: in_code=%b expected 01", in_code);
        end
    endtask

    task automatic test_en_freeze();
        logic [1:0] exp;
        apply_reset();
        sens_ns = 1'b1;
        repeat (4) step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (in_code !== 2'b00) begin
                n_err++;
                $display("FAIL en_frozen cyc %0d: in_code=%b expected 00", i, in_code);
            end
        end
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp = (i == 3) ? 2'b01 : 2'b00;
            n_vec++;
            if (in_code !== exp) begin
                n_err++;
                $display("FAIL en_resume edge %0d: in_code=%b expected %b", i, in_code, exp);
            end
        end
    endtask

    task automatic test_random();
        int hold_ns, hold_ew, hold_o;
        logic [3:0] o_tab [4];
        o_tab[0] = 4'b1001; o_tab[1] = 4'b0110; o_tab[2] = 4'b0101; o_tab[3] = 4'b1010;
        apply_reset();
        hold_ns = 0; hold_ew = 0; hold_o = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_ns == 0) begin
                sens_ns = ~sens_ns;
                hold_ns = $urandom_range(1, 12);
            end
            if (hold_ew == 0) begin
                sens_ew = ~sens_ew;
                hold_ew = $urandom_range(1, 12);
            end
            if (hold_o == 0) begin
                o = o_tab[$urandom_range(0, 3)];
                hold_o = $urandom_range(1, 15);
            end
            en = ($urandom_range(0, 9) != 0);
            hold_ns--; hold_ew--; hold_o--;
            step();
            n_vec++;
            if (in_code !== m_lat) begin
                n_err++;
                $display("FAIL random cyc %0d: in_code=%b model=%b", i, in_code, m_lat);
            end
`ifdef TRAFFIC_ENC_STUCK_EN
            n_vec++;
            if (stuck !== m_stk) begin
                n_err++;
                $display("FAIL random_stuck cyc %0d: stuck=%b model=%b", i, stuck, m_stk);
            end
`endif
        end
        en = 1'b1;
    endtask

`ifdef TRAFFIC_ENC_STUCK_EN
    task automatic test_stuck();
        apply_reset();
        sens_ns = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_vec++;
            if (in_code !== m_lat || stuck !== m_stk) begin
                n_err++;
                $display("FAIL stuck_track cyc %0d: in_code=%b stuck=%b model %b/%b",
                         i, in_code, stuck, m_lat, m_stk);
            end
        end
        n_vec++;
        if (stuck !== 2'b01 || in_code !== 2'b00) begin
            n_err++;
            $display("FAIL stuck_set: stuck=%b in_code=%b expected 01/00", stuck, in_code);
        end
        sens_ns = 1'b0;
        repeat (10) step();
        n_vec++;
        if (stuck !== 2'b00) begin
            n_err++;
            $display("FAIL stuck_clear: stuck=%b expected 00", stuck);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_ns_demand();
        test_bounce();
        test_both_simultaneous();
        test_en_freeze();
`ifdef TRAFFIC_ENC_STUCK_EN
        test_stuck();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_traffic_request_encoder
